// File: rtl/wb_controller.sv
// wb_controller: sequences the single register-file write port.
// Accepts ALU writeback requests and load requests, issues the RAM read
// for a load, waits out the RAM latency and writes the returned data.
// An in-flight load blocks ALU writes to the same destination register
// (write-after-write hazard) and blocks every ALU write during its capture
// cycle, so the two sources never write in the same cycle.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   alu_valid/alu_rd/alu_result        ALU writeback request
//   alu_ready                          ALU request may be accepted (combinational)
//   ldr_valid/ldr_rd/ldr_addr          load request
//   ldr_ready                          load may be accepted (IDLE only)
//   ram_re/ram_addr, ram_data          RAM read strobe/address, returned data
//   rf_we/rf_waddr/rf_wdata            register-file write port
//   mux_sel                            writeback select, 0 ALU / 1 RAM
//   busy                               load in flight
module wb_controller #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_ready,
    input  logic              ldr_valid,
    input  logic [REG_AW-1:0] ldr_rd,
    input  logic [ADDR_W-1:0] ldr_addr,
    output logic              ldr_ready,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mux_sel,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    // WAIT lasts RAM_LAT-1 cycles; the counter starts at RAM_LAT-2.
    localparam int unsigned CntInit = (RAM_LAT > 1) ? RAM_LAT - 2 : 0;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ram_re_q, ram_re_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                mux_sel_q, mux_sel_d;

    assign alu_ready = (state_q != StCapture) && !(pending_q && (alu_rd == pend_rd_q));
    assign ldr_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    assign ram_re   = ram_re_q;
    assign ram_addr = ram_addr_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign mux_sel  = mux_sel_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_rd_d  = pend_rd_q;
        cnt_d      = cnt_q;
        ram_re_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        mux_sel_d  = mux_sel_q;

        case (state_q)
            StIdle: begin
                if (ldr_valid) begin
                    pending_d  = 1'b1;
                    pend_rd_d  = ldr_rd;
                    ram_addr_d = ldr_addr;
                    ram_re_d   = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (RAM_LAT > 1) begin
                    cnt_d   = 4'(CntInit);
                    state_d = StWait;
                end else begin
                    state_d = StCapture;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = pend_rd_q;
                rf_wdata_d = ram_data;
                mux_sel_d  = 1'b1;
                pending_d  = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // alu_ready is low in CAPTURE, so this never collides with the load write.
        if (alu_valid && alu_ready) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_result;
            mux_sel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            pend_rd_q  <= '0;
            cnt_q      <= '0;
            ram_re_q   <= 1'b0;
            ram_addr_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            mux_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_rd_q  <= pend_rd_d;
            cnt_q      <= cnt_d;
            ram_re_q   <= ram_re_d;
            ram_addr_q <= ram_addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            mux_sel_q  <= mux_sel_d;
        end
    end

endmodule

// File: tb/tb_wb_controller.sv
// Bench for wb_controller: u_dut2 uses RAM_LAT=2, u_dut1 uses RAM_LAT=1.
// Expected register writes are queued when stimulus is driven and compared
// by a monitor when rf_we is seen.
module tb_wb_controller;

    localparam logic [31:0] RamKey = 32'h1234_5638;  // ram data = addr ^ RamKey

    typedef struct {
        int          cyc;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ldr_valid, alu_valid1, ldr_valid1;
    logic [3:0]  alu_rd, ldr_rd;
    logic [31:0] alu_result, ldr_addr;

    logic        alu_ready, ldr_ready, ram_re, rf_we, mux_sel, busy;
    logic [31:0] ram_addr, ram_data, rf_wdata;
    logic [3:0]  rf_waddr;
    logic        alu_ready1, ldr_ready1, ram_re1, rf_we1, mux_sel1, busy1;
    logic [31:0] ram_addr1, ram_data1, rf_wdata1;
    logic [3:0]  rf_waddr1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q2[$];
    exp_t q1[$];
    logic [31:0] rf_model [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_controller #(.RAM_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .alu_ready(alu_ready),
        .ldr_valid(ldr_valid), .ldr_rd(ldr_rd), .ldr_addr(ldr_addr), .ldr_ready(ldr_ready),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_data(ram_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mux_sel(mux_sel), .busy(busy)
    );

    wb_controller #(.RAM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid1), .alu_rd(alu_rd), .alu_result(alu_result),
        .alu_ready(alu_ready1),
        .ldr_valid(ldr_valid1), .ldr_rd(ldr_rd), .ldr_addr(ldr_addr), .ldr_ready(ldr_ready1),
        .ram_re(ram_re1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .mux_sel(mux_sel1), .busy(busy1)
    );

    // RAM models: data is valid only in the cycle exactly RAM_LAT after ram_re.
    logic [1:0]  pipe2;
    logic        pipe1;
    logic [31:0] addr_h2, addr_h1;
    initial begin
        pipe2 = '0; pipe1 = 1'b0; addr_h2 = '0; addr_h1 = '0;
    end
    always @(posedge clk) begin
        pipe2   <= {pipe2[0], ram_re};
        pipe1   <= ram_re1;
        addr_h2 <= ram_re ? ram_addr : addr_h2;
        addr_h1 <= ram_re1 ? ram_addr1 : addr_h1;
    end
    assign ram_data  = pipe2[1] ? (addr_h2 ^ RamKey) : 32'hBAD0_BAD0;
    assign ram_data1 = pipe1 ? (addr_h1 ^ RamKey) : 32'hBAD1_BAD1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rf_we) begin
            rf_model[rf_waddr] = rf_wdata;
            if (q2.size() == 0) begin
                check("dut2_unexpected_we", {31'd0, rf_we}, 32'd0);
            end else begin
                e = q2.pop_front();
                check("dut2_we_cycle", cyc, e.cyc);
                check("dut2_waddr", {28'd0, rf_waddr}, {28'd0, e.rd});
                check("dut2_wdata", rf_wdata, e.data);
                check("dut2_mux_sel", {31'd0, mux_sel}, {31'd0, e.sel});
            end
        end
        if (rst_n && rf_we1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_we", {31'd0, rf_we1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_we_cycle", cyc, e.cyc);
                check("dut1_waddr", {28'd0, rf_waddr1}, {28'd0, e.rd});
                check("dut1_wdata", rf_wdata1, e.data);
                check("dut1_mux_sel", {31'd0, mux_sel1}, {31'd0, e.sel});
            end
        end
    end

    initial begin
        int a;
        rst_n = 1'b0;
        alu_valid = 1'b0; ldr_valid = 1'b0; alu_valid1 = 1'b0; ldr_valid1 = 1'b0;
        alu_rd = '0; ldr_rd = '0; alu_result = '0; ldr_addr = '0;
        for (int i = 0; i < 16; i++) rf_model[i] = '0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ldr_ready", {31'd0, ldr_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_ram_re", {31'd0, ram_re}, 32'd0);
        check("rst_mux_sel", {31'd0, mux_sel}, 32'd0);

        // ALU only
        step(); a = cyc;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_result = 32'hDEAD_BEEF;
        q2.push_back('{a + 1, 4'd3, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        check("alu_ready_idle", {31'd0, alu_ready}, 32'd1);
        step(); alu_valid = 1'b0;
        step(2);

        // Load only
        a = cyc;
        ldr_valid = 1'b1; ldr_rd = 4'd5; ldr_addr = 32'h40;
        q2.push_back('{a + 4, 4'd5, 32'h1234_5678, 1'b1});
        @(negedge clk);
        check("ld_ready_idle", {31'd0, ldr_ready}, 32'd1);
        step(); ldr_valid = 1'b0;
        @(negedge clk);
        check("ld_ram_re_c1", {31'd0, ram_re}, 32'd1);
        check("ld_ram_addr_c1", ram_addr, 32'h40);
        check("ld_busy_c1", {31'd0, busy}, 32'd1);
        check("ld_ready_c1", {31'd0, ldr_ready}, 32'd0);
        step();
        @(negedge clk);
        check("ld_ram_re_c2", {31'd0, ram_re}, 32'd0);
        check("ld_busy_c2", {31'd0, busy}, 32'd1);
        check("ld_ready_c2", {31'd0, ldr_ready}, 32'd0);
        step();
        @(negedge clk);
        check("ld_busy_c3", {31'd0, busy}, 32'd1);
        check("ld_ready_c3", {31'd0, ldr_ready}, 32'd0);
        step();
        @(negedge clk);
        check("ld_busy_c4", {31'd0, busy}, 32'd0);
        check("ld_ready_c4", {31'd0, ldr_ready}, 32'd1);
        step();
        @(negedge clk);
        check("ld_mux_hold", {31'd0, mux_sel}, 32'd1);
        check("ld_wdata_hold", rf_wdata, 32'h1234_5678);
        step();

        // Port conflict: ALU to r2 while load to r5 is in flight
        a = cyc;
        ldr_valid = 1'b1; ldr_rd = 4'd5; ldr_addr = 32'h44;
        q2.push_back('{a + 4, 4'd5, 32'h44 ^ RamKey, 1'b1});
        step(); ldr_valid = 1'b0; alu_rd = 4'd2; alu_result = 32'hA5A5_0002;
        @(negedge clk);
        check("pc_alu_ready_issue", {31'd0, alu_ready}, 32'd1);
        step();
        @(negedge clk);
        check("pc_alu_ready_wait", {31'd0, alu_ready}, 32'd1);
        step(); alu_valid = 1'b1;
        @(negedge clk);
        check("pc_alu_ready_capture", {31'd0, alu_ready}, 32'd0);
        step();
        q2.push_back('{a + 5, 4'd2, 32'hA5A5_0002, 1'b0});
        @(negedge clk);
        check("pc_alu_ready_after", {31'd0, alu_ready}, 32'd1);
        step(); alu_valid = 1'b0;
        step(2);

        // WAW hazard on r7
        a = cyc;
        ldr_valid = 1'b1; ldr_rd = 4'd7; ldr_addr = 32'h80;
        q2.push_back('{a + 4, 4'd7, 32'h80 ^ RamKey, 1'b1});
        step(); ldr_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_result = 32'h7777_0007;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("waw_alu_ready_blocked", {31'd0, alu_ready}, 32'd0);
            step();
        end
        q2.push_back('{a + 5, 4'd7, 32'h7777_0007, 1'b0});
        @(negedge clk);
        check("waw_alu_ready_released", {31'd0, alu_ready}, 32'd1);
        step(); alu_valid = 1'b0;
        step(2);
        check("waw_final_r7", rf_model[7], 32'h7777_0007);

        // Simultaneous ALU + load to r4, both latencies
        a = cyc;
        alu_valid = 1'b1; alu_valid1 = 1'b1; alu_rd = 4'd4; alu_result = 32'h4444_0004;
        ldr_valid = 1'b1; ldr_valid1 = 1'b1; ldr_rd = 4'd4; ldr_addr = 32'hC0;
        q2.push_back('{a + 1, 4'd4, 32'h4444_0004, 1'b0});
        q2.push_back('{a + 4, 4'd4, 32'hC0 ^ RamKey, 1'b1});
        q1.push_back('{a + 1, 4'd4, 32'h4444_0004, 1'b0});
        q1.push_back('{a + 3, 4'd4, 32'hC0 ^ RamKey, 1'b1});
        @(negedge clk);
        check("sim_alu_ready1", {31'd0, alu_ready1}, 32'd1);
        check("sim_ldr_ready1", {31'd0, ldr_ready1}, 32'd1);
        step();
        alu_valid = 1'b0; alu_valid1 = 1'b0; ldr_valid = 1'b0; ldr_valid1 = 1'b0;
        @(negedge clk);
        check("sim_busy1", {31'd0, busy1}, 32'd1);
        step(5);

        // Reset in the middle of WAIT: the load must never write back
        ldr_valid = 1'b1; ldr_rd = 4'd9; ldr_addr = 32'h10;
        step(); ldr_valid = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ldr_ready", {31'd0, ldr_ready}, 32'd1);
        check("mid_rst_ram_re", {31'd0, ram_re}, 32'd0);
        check("mid_rst_ram_addr", ram_addr, 32'd0);
        check("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("mid_rst_waddr", {28'd0, rf_waddr}, 32'd0);
        check("mid_rst_wdata", rf_wdata, 32'd0);
        check("mid_rst_mux_sel", {31'd0, mux_sel}, 32'd0);
        step(); rst_n = 1'b1;
        step(6);
        @(negedge clk);
        check("post_rst_ldr_ready", {31'd0, ldr_ready}, 32'd1);
        check("dut2_queue_drained", q2.size(), 32'd0);
        check("dut1_queue_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
